// File: rtl/wb_reg_master_if.sv
// Wishbone classic bus bundle; used for both the host-facing and the target-facing port.
interface wb_reg_master_if #(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_BUS_WIDTH = 32
);
  logic                          cyc;
  logic                          stb;
  logic                          we;
  logic [DATA_BUS_WIDTH/8-1:0]   sel;
  logic [ADDR_BUS_WIDTH-1:0]     addr;
  logic [DATA_BUS_WIDTH-1:0]     data_w;
  logic [DATA_BUS_WIDTH-1:0]     data_r;
  logic                          ack;
  logic                          err;

  modport master (
    output cyc, stb, we, sel, addr, data_w,
    input  data_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, sel, addr, data_w,
    output data_r, ack, err
  );
endinterface

// File: rtl/wb_reg_master.sv
// Register-programmed Wishbone master: the host loads ADDR/WDATA/CTRL, the block runs one
// single-beat transfer on the target bus and reports the outcome in STATUS/RDATA.
module wb_reg_master #(
  parameter int          DATA_BUS_WIDTH  = 32,
  parameter int          ADDR_BUS_WIDTH  = 32,
  parameter int          ADDR_WIDTH      = 4,
  parameter int unsigned TIMEOUT_DEFAULT = 255
) (
  input  logic              clk,
  input  logic              rst,
  wb_reg_master_if.slave    wb,
  wb_reg_master_if.master   m_wb
);

  localparam int ADDR_LSB = $clog2(DATA_BUS_WIDTH / 8);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [0:0]                state;
  logic                      ctl_we;
  logic [3:0]                ctl_sel;
  logic [ADDR_BUS_WIDTH-1:0] addr_q;
  logic [31:0]               wdata_q;
  logic [31:0]               rdata_q;
  logic [15:0]               timeout_q;
  logic [15:0]               limit_q;
  logic [15:0]               count_q;
  logic                      done_flag;
  logic                      ack_flag;
  logic                      err_flag;
  logic                      to_flag;
  logic                      ack_q;
  logic [31:0]               rd_q;

  logic [ADDR_WIDTH-1:0]     idx;
  logic                      accept;
  logic                      busy;
  logic [31:0]               status;
  logic [31:0]               rd_mux;
  logic                      unused_in;

  assign idx    = wb.addr[ADDR_WIDTH+ADDR_LSB-1:ADDR_LSB];
  assign accept = wb.stb && !ack_q;
  assign busy   = (state == ACTIVE);
  assign status = {12'h000, ctl_sel, 10'h000, ctl_we, to_flag, err_flag, ack_flag, done_flag, busy};

  assign unused_in = ^{wb.cyc, wb.sel, wb.addr[ADDR_LSB-1:0],
                       wb.addr[ADDR_BUS_WIDTH-1:ADDR_WIDTH+ADDR_LSB]};

  always_comb begin
    rd_mux = '1;
    case (idx)
      ADDR_WIDTH'(0): rd_mux = status;
      ADDR_WIDTH'(1): rd_mux = 32'(addr_q);
      ADDR_WIDTH'(2): rd_mux = wdata_q;
      ADDR_WIDTH'(3): rd_mux = rdata_q;
      ADDR_WIDTH'(4): rd_mux = {16'h0000, timeout_q};
      default:        rd_mux = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ctl_we    <= 1'b0;
      ctl_sel   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      timeout_q <= 16'(TIMEOUT_DEFAULT);
      limit_q   <= '0;
      count_q   <= '0;
      done_flag <= 1'b0;
      ack_flag  <= 1'b0;
      err_flag  <= 1'b0;
      to_flag   <= 1'b0;
      ack_q     <= 1'b0;
      rd_q      <= '0;
    end else begin
      ack_q <= accept;
      if (accept) rd_q <= rd_mux;

      if (accept && wb.we) begin
        if (idx == ADDR_WIDTH'(4)) timeout_q <= wb.data_w[15:0];
        if (!busy) begin
          case (idx)
            ADDR_WIDTH'(0): begin
              ctl_we  <= wb.data_w[1];
              ctl_sel <= wb.data_w[19:16];
              if (wb.data_w[0]) begin
                state     <= ACTIVE;
                done_flag <= 1'b0;
                ack_flag  <= 1'b0;
                err_flag  <= 1'b0;
                to_flag   <= 1'b0;
                count_q   <= '0;
                // Snapshot the limit so a TIMEOUT rewrite mid-transfer only affects the next one.
                limit_q   <= timeout_q;
              end
            end
            ADDR_WIDTH'(1): addr_q  <= wb.data_w[ADDR_BUS_WIDTH-1:0];
            ADDR_WIDTH'(2): wdata_q <= wb.data_w;
            default: ;
          endcase
        end
      end

      if (busy) begin
        if (m_wb.err) begin
          state     <= IDLE;
          err_flag  <= 1'b1;
          done_flag <= 1'b1;
        end else if (m_wb.ack) begin
          state     <= IDLE;
          ack_flag  <= 1'b1;
          done_flag <= 1'b1;
          if (!ctl_we) rdata_q <= m_wb.data_r;
        end else if (limit_q != '0 && count_q + 16'd1 == limit_q) begin
          state     <= IDLE;
          to_flag   <= 1'b1;
          done_flag <= 1'b1;
        end else begin
          count_q <= count_q + 16'd1;
        end
      end
    end
  end

  assign m_wb.cyc    = busy;
  assign m_wb.stb    = busy;
  assign m_wb.we     = ctl_we;
  assign m_wb.sel    = ctl_sel;
  assign m_wb.addr   = addr_q;
  assign m_wb.data_w = wdata_q;

  assign wb.ack    = ack_q;
  assign wb.data_r = rd_q;
  assign wb.err    = 1'b0;

endmodule

// File: tb/tb_wb_reg_master.sv
// Bench for wb_reg_master: host-side register accesses plus a scripted target responder,
// checked against a transaction-level model of the register file and transfer outcome.
module tb_wb_reg_master;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_reg_master_if #(.ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32)) hb ();
  wb_reg_master_if #(.ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32)) mb ();

  wb_reg_master #(
    .DATA_BUS_WIDTH (32),
    .ADDR_BUS_WIDTH (32),
    .ADDR_WIDTH     (4),
    .TIMEOUT_DEFAULT(255)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .wb   (hb),
    .m_wb (mb)
  );

  int checks = 0;
  int errors = 0;

  // Target responder controls and observations
  int          resp_kind = 0;   // 0 none, 1 ack, 2 err, 3 ack+err
  int          resp_at   = 1;   // respond during this stb cycle (1 = first)
  logic [31:0] resp_data = '0;
  bit          idle_noise = 1'b0;
  int          stb_cnt = 0;
  int          bursts  = 0;
  int          last_len = 0;
  logic [31:0] cap_addr, cap_data;
  logic [3:0]  cap_sel;
  logic        cap_we;

  // Reference model of the visible register state
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [15:0] m_to;
  logic [3:0]  m_sel;
  logic        m_we, m_done, m_ack, m_err, m_tof;

  function automatic logic [31:0] exp_status(input logic busy_bit);
    return (32'(m_sel) << 16) | (32'(m_we) << 5) | (32'(m_tof) << 4) | (32'(m_err) << 3) |
           (32'(m_ack) << 2) | (32'(m_done) << 1) | 32'(busy_bit);
  endfunction

  task automatic model_reset();
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_to = 16'd255;
    m_sel = '0; m_we = 1'b0; m_done = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_tof = 1'b0;
  endtask

  initial begin
    mb.ack = 1'b0; mb.err = 1'b0; mb.data_r = '0;
    forever begin
      @(posedge clk); #2;
      if (mb.cyc && mb.stb) begin
        if (stb_cnt == 0) bursts++;
        stb_cnt++;
        if (stb_cnt == 1) begin
          cap_addr = mb.addr; cap_data = mb.data_w; cap_sel = mb.sel; cap_we = mb.we;
        end
      end else begin
        if (stb_cnt != 0) last_len = stb_cnt;
        stb_cnt = 0;
      end
      mb.ack = 1'b0;
      mb.err = 1'b0;
      if (stb_cnt != 0 && stb_cnt == resp_at && resp_kind != 0) begin
        mb.ack    = resp_kind[0];
        mb.err    = resp_kind[1];
        mb.data_r = resp_data;
      end else if (stb_cnt == 0 && idle_noise) begin
        mb.ack    = 1'($urandom);
        mb.err    = 1'($urandom);
        mb.data_r = $urandom;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired got timeout required completion");
    $fatal(1);
  end

  task automatic host_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             output logic [31:0] rd);
    logic got;
    got = 1'b0;
    rd  = '0;
    @(negedge clk);
    hb.cyc = 1'b1; hb.stb = 1'b1; hb.we = we; hb.addr = adr; hb.data_w = dat;
    hb.sel = 4'($urandom);
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (hb.ack === 1'b1) begin
        got = 1'b1;
        rd  = hb.data_r;
      end
    end
    hb.stb = 1'b0; hb.we = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL host_ack addr %h got no ack required ack within 4 cycles", adr);
    end
  endtask

  task automatic host_write(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    host_access(1'b1, adr, dat, dummy);
  endtask

  task automatic host_read(input logic [31:0] adr, output logic [31:0] rd);
    host_access(1'b0, adr, 32'h0, rd);
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk); #3;
      if (!mb.cyc) ok = 1'b1;
    end
  endtask

  task automatic run_txn(input logic [31:0] adr, input logic [31:0] wd, input logic [31:0] rsp,
                         input logic we, input logic [3:0] sel, input int kind, input int at,
                         input string tag);
    logic [31:0] rd;
    logic        ok;
    int          b0, exp_len;
    host_write(32'h4, adr); m_addr  = adr;
    host_write(32'h8, wd);  m_wdata = wd;
    resp_kind = kind; resp_at = at; resp_data = rsp;
    m_sel = sel; m_we = we; m_done = 1'b1; m_ack = 1'b0; m_err = 1'b0; m_tof = 1'b0;
    if (m_to != 0 && (kind == 0 || at > int'(m_to))) begin
      exp_len = int'(m_to);
      m_tof   = 1'b1;
    end else begin
      exp_len = at;
      if (kind >= 2) m_err = 1'b1;
      else begin
        m_ack = 1'b1;
        if (!we) m_rdata = rsp;
      end
    end
    b0 = bursts;
    host_write(32'h0, {12'h000, sel, 14'h0000, we, 1'b1});
    wait_idle(ok);
    resp_kind = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL %s idle got cyc stuck required cyc low", tag); end
    checks++;
    if (bursts !== b0 + 1) begin errors++; $display("FAIL %s bursts got %0d required %0d", tag, bursts - b0, 1); end
    checks++;
    if (last_len !== exp_len) begin errors++; $display("FAIL %s len got %0d required %0d", tag, last_len, exp_len); end
    checks++;
    if (cap_addr !== adr) begin errors++; $display("FAIL %s m_addr got %h required %h", tag, cap_addr, adr); end
    checks++;
    if (cap_data !== wd) begin errors++; $display("FAIL %s m_data got %h required %h", tag, cap_data, wd); end
    checks++;
    if (cap_sel !== sel || cap_we !== we) begin
      errors++; $display("FAIL %s sel_we got %h/%b required %h/%b", tag, cap_sel, cap_we, sel, we);
    end
    host_read(32'h0, rd);
    checks++;
    if (rd !== exp_status(1'b0)) begin errors++; $display("FAIL %s status got %h required %h", tag, rd, exp_status(1'b0)); end
    host_read(32'hC, rd);
    checks++;
    if (rd !== m_rdata) begin errors++; $display("FAIL %s rdata got %h required %h", tag, rd, m_rdata); end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b1;
    hb.cyc = 1'b1; hb.stb = 1'b1; hb.we = 1'b0; hb.sel = '0; hb.addr = '0; hb.data_w = '0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (hb.ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b required 0", hb.ack); end
    end
    checks++;
    if ({mb.cyc, mb.stb, mb.we, mb.sel} !== 7'b0) begin
      errors++; $display("FAIL rst_mbus got %b required 0", {mb.cyc, mb.stb, mb.we, mb.sel});
    end
    checks++;
    if (hb.data_r !== 32'h0 || hb.err !== 1'b0) begin
      errors++; $display("FAIL rst_host got %h/%b required 0/0", hb.data_r, hb.err);
    end
    @(negedge clk); hb.stb = 1'b0; rst = 1'b0;
    model_reset();
    host_read(32'h0, rd);  checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_status got %h required 0", rd); end
    host_read(32'h4, rd);  checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_addr got %h required 0", rd); end
    host_read(32'h8, rd);  checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h required 0", rd); end
    host_read(32'hC, rd);  checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h required 0", rd); end
    host_read(32'h10, rd); checks++;
    if (rd !== 32'h0000_00FF) begin errors++; $display("FAIL rst_timeout got %h required 000000ff", rd); end
    host_read(32'h1C, rd); checks++;
    if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_unmapped got %h required ffffffff", rd); end
  endtask

  task automatic test_write();
    logic [31:0] rd;
    run_txn(32'h100, 32'hDEAD_BEEF, 32'h0, 1'b1, 4'hF, 1, 3, "write");
    host_read(32'h0, rd); checks++;
    if (rd !== 32'h000F_0026) begin errors++; $display("FAIL write_status got %h required 000f0026", rd); end
  endtask

  task automatic test_read();
    logic [31:0] rd;
    run_txn(32'h200, 32'h0, 32'h1234_5678, 1'b0, 4'hF, 1, 1, "read");
    host_read(32'hC, rd); checks++;
    if (rd !== 32'h1234_5678) begin errors++; $display("FAIL read_rdata got %h required 12345678", rd); end
    host_read(32'h0, rd); checks++;
    if (rd !== 32'h000F_0006) begin errors++; $display("FAIL read_status got %h required 000f0006", rd); end
  endtask

  task automatic test_ack_err();
    logic [31:0] rd;
    run_txn(32'h204, 32'h0, 32'hBAD0_BAD0, 1'b0, 4'hF, 3, 2, "ackerr");
    host_read(32'hC, rd); checks++;
    if (rd !== 32'h1234_5678) begin errors++; $display("FAIL ackerr_rdata got %h required 12345678", rd); end
    host_read(32'h0, rd); checks++;
    if (rd !== 32'h000F_000A) begin errors++; $display("FAIL ackerr_status got %h required 000f000a", rd); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    host_write(32'h10, 32'h4); m_to = 16'd4;
    run_txn(32'h208, 32'h0, 32'h0, 1'b0, 4'hF, 0, 1, "timeout");
    host_read(32'h0, rd); checks++;
    if (rd !== 32'h000F_0012) begin errors++; $display("FAIL timeout_status got %h required 000f0012", rd); end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] rd, rd_before;
    logic        ok;
    int          b0;
    host_write(32'h10, 32'd20);        m_to = 16'd20;
    host_write(32'h4, 32'h40);         m_addr = 32'h40;
    host_write(32'h8, 32'h5555_AAAA);  m_wdata = 32'h5555_AAAA;
    resp_kind = 0;
    b0 = bursts;
    host_write(32'h0, 32'h0003_0001);
    m_sel = 4'h3; m_we = 1'b0; m_done = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_tof = 1'b0;
    host_write(32'h4, 32'h300);
    host_write(32'h8, 32'h1);
    host_write(32'h0, 32'h000C_0003);
    host_read(32'h0, rd); checks++;
    if (rd !== exp_status(1'b1)) begin errors++; $display("FAIL busy_status got %h required %h", rd, exp_status(1'b1)); end
    host_write(32'h10, 32'd7); m_to = 16'd7;
    host_read(32'h10, rd); checks++;
    if (rd !== 32'd7) begin errors++; $display("FAIL busy_timeout_wr got %h required 00000007", rd); end
    wait_idle(ok);
    m_done = 1'b1; m_tof = 1'b1;
    checks++;
    if (!ok || last_len !== 20) begin errors++; $display("FAIL busy_len got %0d required 20", last_len); end
    checks++;
    if (bursts !== b0 + 1 || cap_addr !== 32'h40) begin
      errors++; $display("FAIL busy_single got %0d txns addr %h required 1 txn addr 00000040", bursts - b0, cap_addr);
    end
    host_read(32'h4, rd); checks++;
    if (rd !== m_addr) begin errors++; $display("FAIL busy_addr got %h required %h", rd, m_addr); end
    host_read(32'h8, rd); checks++;
    if (rd !== m_wdata) begin errors++; $display("FAIL busy_wdata got %h required %h", rd, m_wdata); end
    host_read(32'h0, rd); checks++;
    if (rd !== exp_status(1'b0)) begin errors++; $display("FAIL busy_final got %h required %h", rd, exp_status(1'b0)); end
    run_txn(32'h44, 32'h0, 32'h0, 1'b1, 4'h1, 0, 1, "newlimit");
    host_read(32'hC, rd_before);
    b0 = bursts;
    idle_noise = 1'b1;
    repeat (12) @(posedge clk);
    idle_noise = 1'b0;
    repeat (2) @(posedge clk);
    host_read(32'h0, rd); checks++;
    if (rd !== exp_status(1'b0) || bursts !== b0) begin
      errors++; $display("FAIL idle_noise status got %h required %h", rd, exp_status(1'b0));
    end
    host_read(32'hC, rd); checks++;
    if (rd !== rd_before) begin errors++; $display("FAIL idle_noise rdata got %h required %h", rd, rd_before); end
  endtask

  task automatic test_reg_map();
    logic [31:0] rd;
    int          b0;
    host_write(32'hC, 32'hCAFE_F00D);
    host_read(32'hC, rd); checks++;
    if (rd !== m_rdata) begin errors++; $display("FAIL map_rdata_ro got %h required %h", rd, m_rdata); end
    host_write(32'h24, 32'h1234_5678);
    host_read(32'h24, rd); checks++;
    if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL map_idx9 got %h required ffffffff", rd); end
    host_read(32'h3C, rd); checks++;
    if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL map_idx15 got %h required ffffffff", rd); end
    host_write(32'h10, 32'hABCD_1234); m_to = 16'h1234;
    host_read(32'h10, rd); checks++;
    if (rd !== 32'h0000_1234) begin errors++; $display("FAIL map_timeout16 got %h required 00001234", rd); end
    host_write(32'h8000_0007, 32'h0BAD_C0DE); m_addr = 32'h0BAD_C0DE;
    host_read(32'h4, rd); checks++;
    if (rd !== m_addr) begin errors++; $display("FAIL map_alias got %h required %h", rd, m_addr); end
    @(posedge clk); #1; checks++;
    if (hb.ack !== 1'b0 || hb.err !== 1'b0) begin
      errors++; $display("FAIL ack_pulse got ack %b err %b required 0 0", hb.ack, hb.err);
    end
    b0 = bursts;
    host_write(32'h0, 32'h0005_0002); m_sel = 4'h5; m_we = 1'b1;
    repeat (3) @(posedge clk);
    host_read(32'h0, rd); checks++;
    if (rd !== exp_status(1'b0) || bursts !== b0) begin
      errors++; $display("FAIL ctrl_nostart got %h required %h", rd, exp_status(1'b0));
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic        we;
    logic [3:0]  sel;
    int          kind, at, to, ix;
    for (int n = 0; n < 12; n++) begin
      we   = 1'($urandom);
      sel  = 4'($urandom);
      kind = int'($urandom_range(0, 3));
      at   = int'($urandom_range(1, 6));
      to   = int'($urandom_range(0, 8));
      if (kind == 0 && to == 0) to = 3;
      host_write(32'h10, {16'($urandom), 16'(to)}); m_to = 16'(to);
      run_txn($urandom, $urandom, $urandom, we, sel, kind, at, "random");
      ix = int'($urandom_range(5, 15));
      host_read(32'(ix) << 2, rd); checks++;
      if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL random_unmapped idx %0d got %h required ffffffff", ix, rd); end
    end
  endtask

  task automatic test_rst_active();
    logic [31:0] rd;
    host_write(32'h10, 32'h0); m_to = '0;
    resp_kind = 0;
    host_write(32'h0, 32'h0001_0003);
    repeat (5) @(posedge clk);
    #1; checks++;
    if (mb.cyc !== 1'b1) begin errors++; $display("FAIL rst_act_pre got cyc %b required 1", mb.cyc); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; checks++;
    if (mb.cyc !== 1'b0 || mb.stb !== 1'b0) begin
      errors++; $display("FAIL rst_act_drop got cyc %b stb %b required 0 0", mb.cyc, mb.stb);
    end
    @(negedge clk); rst = 1'b0;
    model_reset();
    host_read(32'h0, rd); checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_act_status got %h required 0", rd); end
    host_read(32'h10, rd); checks++;
    if (rd !== 32'h0000_00FF) begin errors++; $display("FAIL rst_act_timeout got %h required 000000ff", rd); end
    host_read(32'h4, rd); checks++;
    if (rd !== m_addr) begin errors++; $display("FAIL rst_act_addr got %h required %h", rd, m_addr); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ack_err();
    test_timeout();
    test_busy_ignore();
    test_reg_map();
    test_random();
    test_rst_active();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_reg_master.md
WB_REG_MASTER -- requirements
Module: wb_reg_master

Interface
REQ-001 DATA_BUS_WIDTH, 32, data width of both buses; only 32 supported.
REQ-002 ADDR_BUS_WIDTH, 32, address width of both buses.
REQ-003 ADDR_WIDTH, 4, register-index bits decoded from wb_addr[ADDR_WIDTH+ADDR_LSB-1:ADDR_LSB], ADDR_LSB = log2(DATA_BUS_WIDTH/8).
REQ-004 TIMEOUT_DEFAULT, 255, reset value of TIMEOUT register.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 wb_stb  in  1  host strobe.
REQ-008 wb_we  in  1  host write enable.
REQ-009 wb_sel  in  4  host byte select; ignored, full-word access only.
REQ-010 wb_addr  in  ADDR_BUS_WIDTH  host address.
REQ-011 wb_data_i  in  32  host write data.
REQ-012 wb_ack  out  1  host acknowledge.
REQ-013 wb_data_o  out  32  host read data.
REQ-014 wb_err  out  1  host error; constant 0.
REQ-015 m_wb_cyc  out  1  master cycle.
REQ-016 m_wb_stb  out  1  master strobe.
REQ-017 m_wb_we  out  1  master write enable.
REQ-018 m_wb_sel  out  4  master byte select.
REQ-019 m_wb_addr  out  ADDR_BUS_WIDTH  master address.
REQ-020 m_wb_data_o  out  32  master write data.
REQ-021 m_wb_data_i  in  32  master read data.
REQ-022 m_wb_ack  in  1  target acknowledge.
REQ-023 m_wb_err  in  1  target error.

Function
REQ-024 Host access accepted on an edge where wb_stb=1 and wb_ack=0; wb_ack SHALL be 1 for exactly the following cycle; wb_data_o registered at the same edge.
REQ-025 Register map (index): 0 CTRL/STATUS, 1 ADDR (RW), 2 WDATA (RW), 3 RDATA (RO), 4 TIMEOUT (RW, 16 bits, upper bits read 0); other indices read 0xFFFFFFFF, writes ignored.
REQ-026 CTRL write: bit0 START, bit1 WE, bits[19:16] SEL; STATUS read: bit0 BUSY, bit1 DONE, bit2 ACK, bit3 ERR, bit4 TIMEOUT, bit5 WE, bits[19:16] SEL, others 0.
REQ-027 While BUSY=1, writes to indices 0-2 SHALL be ignored entirely (START included); TIMEOUT writes always take effect, used from next transaction.
REQ-028 FSM states IDLE, ACTIVE; IDLE->ACTIVE on accepted CTRL write with START=1: DONE/ACK/ERR/TIMEOUT cleared, cycle counter cleared, BUSY=1.
REQ-029 In ACTIVE, m_wb_cyc=m_wb_stb=1, m_wb_we/sel/addr/data_o driven from WE, SEL, ADDR, WDATA; first asserted cycle is the one after the START accept edge.
REQ-030 ACTIVE->IDLE at the edge sampling m_wb_err=1: ERR=1, DONE=1.
REQ-031 Else ACTIVE->IDLE at the edge sampling m_wb_ack=1: ACK=1, DONE=1; RDATA <= m_wb_data_i when WE=0, unchanged when WE=1.
REQ-032 Simultaneous m_wb_ack and m_wb_err: error wins, ACK stays 0, RDATA unchanged.
REQ-033 Counter increments each ACTIVE cycle without response; TIMEOUT!=0 and counter reaching TIMEOUT with no response -> IDLE, TIMEOUT flag=1, DONE=1; cyc/stb high exactly TIMEOUT cycles; TIMEOUT=0 disables abort.
REQ-034 m_wb_cyc/m_wb_stb SHALL be 0 in the cycle after leaving ACTIVE; back-to-back transactions have at least one idle cycle between them.
REQ-035 m_wb_ack/m_wb_err seen in IDLE SHALL be ignored.

Reset
REQ-036 On rst: state IDLE, m_wb_cyc=m_wb_stb=m_wb_we=0, m_wb_sel=0, wb_ack=0, wb_err=0, wb_data_o=0, all status flags 0, ADDR=WDATA=RDATA=0, SEL=0, TIMEOUT=TIMEOUT_DEFAULT.
REQ-037 rst during ACTIVE SHALL drop m_wb_cyc/m_wb_stb in the cycle after the reset edge, no flags set.
REQ-038 Host stb present during rst SHALL not be acknowledged.

Verification
REQ-039 Write ADDR=0x100, WDATA=0xDEADBEEF, CTRL=0x000F0003; target acks on 3rd stb cycle -> m_wb_addr=0x100, data 0xDEADBEEF, sel 0xF, we=1; STATUS=0x000F0026.
REQ-040 Read: ADDR=0x200, CTRL=0x000F0001, target acks 1st cycle with 0x12345678 -> RDATA=0x12345678, STATUS=0x000F0006.
REQ-041 TIMEOUT=4, START, no response -> cyc/stb high exactly 4 cycles, STATUS bit4=1, bit1=1, bit0=0.
REQ-042 Ack and err same cycle on read -> STATUS ERR=1, ACK=0, RDATA keeps prior value.
REQ-043 While BUSY write ADDR=0x300 and START -> ADDR unchanged, no second transaction; rst asserted mid-ACTIVE -> cyc low next cycle, STATUS=0.
